// File: rtl/tns_enc_28.sv
// tns_enc_28 - sequential greedy encoder for the 28-wire TNS crosstalk-avoidance code.
//
// Takes a binary word over a valid/ready handshake and produces the 28-bit TNS
// codeword MSB-first by greedy subtraction of the TNS weights. BPC code bits are
// resolved per clock, so a word takes N = 28/BPC encode cycles.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   datain holds a word to encode
//   in_ready   encoder is idle and can accept a word
//   datain     unsigned binary value (`BLEN10_C bits)
//   out_valid  codeout/err hold a finished result
//   out_ready  sink accepts codeout
//   codeout    TNS codeword, bit 27 drives the heaviest wire
//   err        value was not fully representable (non-zero residue after bit 0)
//
// Parameter BPC: code bits per cycle, one of 1, 2, 4, 7, 14, 28.

`ifndef BLEN10_C
`define BLEN10_C 26
`endif
`ifndef TNS01_C
`define TNS01_C 1
`define TNS01_B 2
`define TNS01_A 4
`define TNS02_C 7
`define TNS02_B 13
`define TNS02_A 24
`define TNS03_C 44
`define TNS03_B 81
`define TNS03_A 149
`define TNS04_C 274
`define TNS04_B 504
`define TNS04_A 927
`define TNS05_C 1705
`define TNS05_B 3136
`define TNS05_A 5768
`define TNS06_C 10609
`define TNS06_B 19513
`define TNS06_A 35890
`define TNS07_C 66012
`define TNS07_B 121415
`define TNS07_A 223317
`define TNS08_C 410744
`define TNS08_B 755476
`define TNS08_A 1389537
`define TNS09_C 2555757
`define TNS09_B 4700770
`define TNS09_A 8646064
`define TNS10_C 15902591
`endif

module tns_enc_28 #(
  parameter int BPC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [`BLEN10_C-1:0] datain,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [27:0]          codeout,
  output logic                 err
);

  localparam int BLEN = `BLEN10_C;

  // Bit-position step per cycle and the index of the cycle that finishes bit 0.
  localparam logic [4:0] STEP = 5'(BPC);
  localparam logic [4:0] LAST = 5'(BPC - 1);

  // Weight of code bit i, index 0 = lightest wire.
  localparam logic [BLEN-1:0] WT [28] = '{
    BLEN'(`TNS01_C), BLEN'(`TNS01_B), BLEN'(`TNS01_A),
    BLEN'(`TNS02_C), BLEN'(`TNS02_B), BLEN'(`TNS02_A),
    BLEN'(`TNS03_C), BLEN'(`TNS03_B), BLEN'(`TNS03_A),
    BLEN'(`TNS04_C), BLEN'(`TNS04_B), BLEN'(`TNS04_A),
    BLEN'(`TNS05_C), BLEN'(`TNS05_B), BLEN'(`TNS05_A),
    BLEN'(`TNS06_C), BLEN'(`TNS06_B), BLEN'(`TNS06_A),
    BLEN'(`TNS07_C), BLEN'(`TNS07_B), BLEN'(`TNS07_A),
    BLEN'(`TNS08_C), BLEN'(`TNS08_B), BLEN'(`TNS08_A),
    BLEN'(`TNS09_C), BLEN'(`TNS09_B), BLEN'(`TNS09_A),
    BLEN'(`TNS10_C)
  };

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

  state_t          state;
  logic [BLEN-1:0] rem;
  logic [BLEN-1:0] rem_next;
  logic [27:0]     code;
  logic [27:0]     code_next;
  logic [4:0]      idx;
  logic [4:0]      bit_idx;

  // Accepting only depends on being idle; held low for the whole reset pulse.
  assign in_ready = (state == IDLE) && !rst;

  // BPC greedy steps chained combinationally, heaviest bit first. Because BPC
  // divides 28 and idx starts at 27, idx-k never goes below zero in ENC.
  always_comb begin
    rem_next  = rem;
    code_next = code;
    bit_idx   = '0;
    for (int k = 0; k < BPC; k++) begin
      bit_idx = idx - 5'(k);
      if (rem_next >= WT[bit_idx]) begin
        code_next[bit_idx] = 1'b1;
        rem_next           = rem_next - WT[bit_idx];
      end
    end
  end

  // Control FSM with registered outputs. codeout/err only change on the cycle
  // that resolves bit 0, so a partial codeword is never presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      code      <= '0;
      idx       <= '0;
      codeout   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            rem   <= datain;
            code  <= '0;
            idx   <= 5'd27;
            state <= ENC;
          end
        end
        ENC: begin
          rem  <= rem_next;
          code <= code_next;
          idx  <= idx - STEP;
          if (idx == LAST) begin
            codeout   <= code_next;
            err       <= (rem_next != '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
